// File: rtl/drac_pkg.sv
// Shared types for the core-side instruction-cache fetch path.
package drac_pkg;

   localparam int unsigned ADDR_W         = 40;
   localparam int unsigned IDX_W          = 12;
   localparam int unsigned LINE_W         = 128;
   localparam int unsigned ICACHE_TIMEOUT = 64;
   localparam int unsigned TAG_W          = ADDR_W - 4;

   typedef logic [ADDR_W-1:0]       addr_t;
   typedef logic [IDX_W-1:0]        icache_idx_t;
   typedef logic [ADDR_W-IDX_W-1:0] icache_vpn_t;
   typedef logic [LINE_W-1:0]       icache_line_t;
   typedef logic [TAG_W-1:0]        line_tag_t;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_t;

endpackage

// File: rtl/icache_fetch_req_if.sv
// ICACHE_REQ / ICACHE_RESP bundle between the fetch initiator and the icache.
interface icache_fetch_req_if;
   import drac_pkg::*;

   logic         icache_req_ready_i;
   logic         icache_req_valid_o;
   icache_idx_t  icache_req_idx_o;
   icache_vpn_t  icache_req_vpn_o;
   logic         icache_req_kill_o;
   logic         icache_resp_valid_i;
   icache_line_t icache_resp_data_i;
   addr_t        icache_resp_vaddr_i;

   modport master (
      input  icache_req_ready_i,
      output icache_req_valid_o,
      output icache_req_idx_o,
      output icache_req_vpn_o,
      output icache_req_kill_o,
      input  icache_resp_valid_i,
      input  icache_resp_data_i,
      input  icache_resp_vaddr_i
   );

   modport slave (
      output icache_req_ready_i,
      input  icache_req_valid_o,
      input  icache_req_idx_o,
      input  icache_req_vpn_o,
      input  icache_req_kill_o,
      output icache_resp_valid_i,
      output icache_resp_data_i,
      output icache_resp_vaddr_i
   );

endinterface

// File: rtl/fetch_line_buffer.sv
// One-line instruction buffer: tag/data registers, hit compare and word select.
module fetch_line_buffer
   import drac_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         capture,
   input  logic         inval,
   input  icache_line_t line_in,
   input  line_tag_t    tag_in,
   input  line_tag_t    lookup_tag,
   input  logic [1:0]   sel,
   output logic         hit,
   output logic [31:0]  word
);

   logic         line_valid_q;
   icache_line_t data_q;
   line_tag_t    tag_q;

   // NOTE: clocked state is written with <= so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i)        line_valid_q <= 1'b0;
      else if (inval)   line_valid_q <= 1'b0;
      else if (capture) line_valid_q <= 1'b1;
   end

   // NOTE: data and tag have no reset; line_valid_q alone qualifies them.
   always_ff @(posedge clk_i) begin
      if (capture) begin
         data_q <= line_in;
         tag_q  <= tag_in;
      end
   end

   assign hit  = line_valid_q & (tag_q == lookup_tag);
   assign word = data_q[{sel, 5'd0} +: 32];

endmodule

// File: rtl/icache_fetch_req.sv
// Fetch-side icache initiator: PC -> ICACHE_REQ, matching ICACHE_RESP -> one instruction.
module icache_fetch_req
   import drac_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = ICACHE_TIMEOUT
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               pc_valid_i,
   input  addr_t              pc_i,
   output logic               pc_ready_o,
   input  logic               flush_i,
   input  logic               inval_i,
   icache_fetch_req_if.master icache,
   output logic               instr_valid_o,
   output logic [31:0]        instr_o,
   output addr_t              instr_pc_o,
   input  logic               instr_ready_i,
   output logic [15:0]        timeout_cnt_o
);

   fetch_state_t state_q, state_d;
   addr_t        pc_q;
   logic [15:0]  wait_cnt_q, reissue_q;
   logic         ready_q, req_valid_q, kill_q, instr_valid_q;
   logic         ready_d, req_valid_d, kill_d, instr_valid_d;
   logic         accept, resp_match, timed_out, capture, reissue, hit;
   logic [31:0]  word;
   logic         unused_vaddr_bits;

   assign pc_ready_o        = ready_q & ~flush_i;
   assign accept            = pc_valid_i & pc_ready_o;
   assign resp_match        = icache.icache_resp_valid_i &
                              (icache.icache_resp_vaddr_i[ADDR_W-1:4] == pc_q[ADDR_W-1:4]);
   assign timed_out         = (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1));
   assign capture           = (state_q == WAIT) & resp_match & ~flush_i;
   assign reissue           = (state_q == WAIT) & ~resp_match & timed_out & ~flush_i;
   assign unused_vaddr_bits = ^icache.icache_resp_vaddr_i[3:0];

   fetch_line_buffer u_line_buffer (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .capture    (capture),
      .inval      (inval_i),
      .line_in    (icache.icache_resp_data_i),
      .tag_in     (pc_q[ADDR_W-1:4]),
      .lookup_tag (pc_i[ADDR_W-1:4]),
      .sel        (pc_q[3:2]),
      .hit        (hit),
      .word       (word)
   );

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = hit ? HOLD : REQ;
         REQ:     if (icache.icache_req_ready_i) state_d = WAIT;
         WAIT: begin
            if (resp_match)     state_d = HOLD;
            else if (timed_out) state_d = REQ;
         end
         HOLD:    if (instr_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush_i) state_d = IDLE;
   end

   // Outputs are registered from the next state, so they trail the decision by one edge.
   always_comb begin
      ready_d       = (state_d == IDLE);
      req_valid_d   = (state_d == REQ);
      instr_valid_d = (state_d == HOLD);
      if (flush_i)
         kill_d = (state_q == WAIT) | ((state_q == REQ) & icache.icache_req_ready_i);
      else
         kill_d = reissue;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         ready_q       <= 1'b0;
         req_valid_q   <= 1'b0;
         kill_q        <= 1'b0;
         instr_valid_q <= 1'b0;
         wait_cnt_q    <= '0;
         reissue_q     <= '0;
      end else begin
         state_q       <= state_d;
         ready_q       <= ready_d;
         req_valid_q   <= req_valid_d;
         kill_q        <= kill_d;
         instr_valid_q <= instr_valid_d;
         if (state_q == REQ && icache.icache_req_ready_i) wait_cnt_q <= '0;
         else if (state_q == WAIT)                        wait_cnt_q <= wait_cnt_q + 16'd1;
         if (reissue && reissue_q != 16'hFFFF)            reissue_q  <= reissue_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept) pc_q <= pc_i;
   end

   assign icache.icache_req_valid_o = req_valid_q;
   assign icache.icache_req_idx_o   = req_valid_q ? {pc_q[IDX_W-1:4], 4'b0000} : '0;
   assign icache.icache_req_vpn_o   = req_valid_q ? pc_q[ADDR_W-1:IDX_W] : '0;
   assign icache.icache_req_kill_o  = kill_q;
   assign instr_valid_o             = instr_valid_q;
   assign instr_o                   = instr_valid_q ? word : '0;
   assign instr_pc_o                = instr_valid_q ? pc_q : '0;
   assign timeout_cnt_o             = reissue_q;

endmodule

// File: tb/tb_icache_fetch_req.sv
// Directed bench for icache_fetch_req: miss/hit, stale response, timeout, flush, inval, reset.
module tb_icache_fetch_req;
   import drac_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pc_valid = 1'b0;
   addr_t       pc = '0;
   logic        pc_ready;
   logic        flush = 1'b0;
   logic        inval = 1'b0;
   logic        instr_valid;
   logic [31:0] instr;
   addr_t       instr_pc;
   logic        instr_ready = 1'b0;
   logic [15:0] timeout_cnt;

   int total = 0;
   int passed = 0;
   int req_cycles = 0;

   icache_fetch_req_if ic ();

   icache_fetch_req dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .pc_valid_i    (pc_valid),
      .pc_i          (pc),
      .pc_ready_o    (pc_ready),
      .flush_i       (flush),
      .inval_i       (inval),
      .icache        (ic),
      .instr_valid_o (instr_valid),
      .instr_o       (instr),
      .instr_pc_o    (instr_pc),
      .instr_ready_i (instr_ready),
      .timeout_cnt_o (timeout_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (ic.icache_req_valid_o) req_cycles++;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic accept_pc(input addr_t a, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 16 && !ok; i++) begin
         if (pc_ready) ok = 1'b1;
         else step();
      end
      if (ok) begin
         pc_valid = 1'b1;
         pc = a;
         step();
         pc_valid = 1'b0;
      end
   endtask

   task automatic grant_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 16 && !ok; i++) begin
         if (ic.icache_req_valid_o) ok = 1'b1;
         else step();
      end
      ic.icache_req_ready_i = 1'b1;
      step();
      ic.icache_req_ready_i = 1'b0;
   endtask

   task automatic respond(input addr_t va, input icache_line_t l);
      ic.icache_resp_valid_i = 1'b1;
      ic.icache_resp_vaddr_i = va;
      ic.icache_resp_data_i  = l;
      step();
      ic.icache_resp_valid_i = 1'b0;
   endtask

   task automatic consume();
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      total++; if (pc_ready !== 1'b0) $display("FAIL reset_pc_ready: got %b want 0", pc_ready); else passed++;
      total++; if ({ic.icache_req_valid_o, ic.icache_req_kill_o, instr_valid} !== 3'b000)
         $display("FAIL reset_valids: got %b want 000", {ic.icache_req_valid_o, ic.icache_req_kill_o, instr_valid}); else passed++;
      total++; if ({ic.icache_req_idx_o, ic.icache_req_vpn_o, instr, instr_pc, timeout_cnt} !== '0)
         $display("FAIL reset_data: got nonzero idx/vpn/instr/pc/cnt want all 0"); else passed++;
      rst = 1'b0;
      step();
      total++; if (pc_ready !== 1'b1) $display("FAIL reset_ready_after: got %b want 1", pc_ready); else passed++;
   endtask

   task automatic test_miss_then_hit();
      bit ok;
      int r0;
      icache_line_t l = {32'h193, 32'h113, 32'h93, 32'h13};
      accept_pc(40'h1000, ok);
      total++; if (ok !== 1'b1) $display("FAIL miss_accept: got timeout want accepted"); else passed++;
      total++; if (ic.icache_req_valid_o !== 1'b1) $display("FAIL miss_req_valid: got %b want 1", ic.icache_req_valid_o); else passed++;
      total++; if (ic.icache_req_idx_o !== 12'h000 || ic.icache_req_vpn_o !== 28'h1)
         $display("FAIL miss_idx_vpn: got %h/%h want 000/0000001", ic.icache_req_idx_o, ic.icache_req_vpn_o); else passed++;
      grant_req(ok);
      step();
      step();
      respond(40'h1000, l);
      total++; if (instr_valid !== 1'b1 || instr !== 32'h13 || instr_pc !== 40'h1000)
         $display("FAIL miss_instr: got v=%b %h @%h want v=1 00000013 @1000", instr_valid, instr, instr_pc); else passed++;
      consume();
      r0 = req_cycles;
      accept_pc(40'h100C, ok);
      total++; if (instr_valid !== 1'b1 || instr !== 32'h193 || instr_pc !== 40'h100C)
         $display("FAIL hit_instr: got v=%b %h @%h want v=1 00000193 @100c", instr_valid, instr, instr_pc); else passed++;
      total++; if (req_cycles !== r0) $display("FAIL hit_no_req: got %0d req cycles want %0d", req_cycles, r0); else passed++;
      consume();
   endtask

   task automatic test_stale_response();
      bit ok;
      icache_line_t good = {32'h2003, 32'h2002, 32'h2001, 32'h2000};
      accept_pc(40'h2008, ok);
      grant_req(ok);
      total++; if (ok !== 1'b1) $display("FAIL stale_grant: got timeout want request"); else passed++;
      respond(40'h3000, {4{32'hDEAD_BEEF}});
      total++; if (instr_valid !== 1'b0) $display("FAIL stale_dropped: got instr_valid %b want 0", instr_valid); else passed++;
      respond(40'h2000, good);
      total++; if (instr_valid !== 1'b1 || instr !== 32'h2002 || instr_pc !== 40'h2008)
         $display("FAIL stale_instr: got v=%b %h @%h want v=1 00002002 @2008", instr_valid, instr, instr_pc); else passed++;
      consume();
   endtask

   task automatic test_timeout();
      bit ok;
      accept_pc(40'h4000, ok);
      grant_req(ok);
      for (int i = 0; i < 63; i++) step();
      total++; if (ic.icache_req_kill_o !== 1'b0 || ic.icache_req_valid_o !== 1'b0)
         $display("FAIL timeout_early: got kill=%b req=%b want 0/0", ic.icache_req_kill_o, ic.icache_req_valid_o); else passed++;
      step();
      total++; if (ic.icache_req_kill_o !== 1'b1) $display("FAIL timeout_kill: got %b want 1", ic.icache_req_kill_o); else passed++;
      total++; if (ic.icache_req_valid_o !== 1'b1 || ic.icache_req_idx_o !== 12'h000 || ic.icache_req_vpn_o !== 28'h4)
         $display("FAIL timeout_reissue: got v=%b %h/%h want v=1 000/0000004", ic.icache_req_valid_o, ic.icache_req_idx_o, ic.icache_req_vpn_o); else passed++;
      total++; if (timeout_cnt !== 16'd1) $display("FAIL timeout_cnt: got %0d want 1", timeout_cnt); else passed++;
      step();
      total++; if (ic.icache_req_kill_o !== 1'b0) $display("FAIL timeout_kill_pulse: got %b want 0", ic.icache_req_kill_o); else passed++;
      grant_req(ok);
      respond(40'h4000, {32'h4003, 32'h4002, 32'h4001, 32'h4000});
      total++; if (instr_valid !== 1'b1 || instr !== 32'h4000)
         $display("FAIL timeout_complete: got v=%b %h want v=1 00004000", instr_valid, instr); else passed++;
      consume();
   endtask

   task automatic test_flush();
      bit ok;
      int r0;
      icache_line_t l = {32'h5003, 32'h5002, 32'h5001, 32'h5000};
      accept_pc(40'h5000, ok);
      grant_req(ok);
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      total++; if (ic.icache_req_kill_o !== 1'b1 || instr_valid !== 1'b0)
         $display("FAIL flush_kill: got kill=%b v=%b want 1/0", ic.icache_req_kill_o, instr_valid); else passed++;
      respond(40'h5000, l);
      total++; if (instr_valid !== 1'b0 || ic.icache_req_kill_o !== 1'b0)
         $display("FAIL flush_late_resp: got v=%b kill=%b want 0/0", instr_valid, ic.icache_req_kill_o); else passed++;
      flush = 1'b1;
      pc_valid = 1'b1;
      pc = 40'h4004;
      #1;
      total++; if (pc_ready !== 1'b0) $display("FAIL flush_gates_ready: got %b want 0", pc_ready); else passed++;
      step();
      flush = 1'b0;
      pc_valid = 1'b0;
      total++; if (instr_valid !== 1'b0 || ic.icache_req_valid_o !== 1'b0)
         $display("FAIL flush_pc_dropped: got v=%b req=%b want 0/0", instr_valid, ic.icache_req_valid_o); else passed++;
      r0 = req_cycles;
      accept_pc(40'h4004, ok);
      total++; if (instr_valid !== 1'b1 || instr !== 32'h4001 || req_cycles !== r0)
         $display("FAIL flush_buffer_kept: got v=%b %h reqs=%0d want v=1 00004001 reqs=%0d", instr_valid, instr, req_cycles, r0); else passed++;
      consume();
      accept_pc(40'h5000, ok);
      total++; if (ic.icache_req_valid_o !== 1'b1 || ic.icache_req_vpn_o !== 28'h5)
         $display("FAIL flush_new_req: got v=%b vpn=%h want 1/0000005", ic.icache_req_valid_o, ic.icache_req_vpn_o); else passed++;
      grant_req(ok);
      respond(40'h5000, l);
      total++; if (instr !== 32'h5000) $display("FAIL flush_refetch: got %h want 00005000", instr); else passed++;
      consume();
   endtask

   task automatic test_backpressure_inval();
      bit ok;
      int bad = 0;
      accept_pc(40'h5004, ok);
      for (int i = 0; i < 5; i++) begin
         step();
         if (instr_valid !== 1'b1 || instr !== 32'h5001 || instr_pc !== 40'h5004) bad++;
      end
      total++; if (bad !== 0) $display("FAIL hold_stable: got %0d unstable cycles want 0", bad); else passed++;
      consume();
      inval = 1'b1;
      step();
      inval = 1'b0;
      accept_pc(40'h5008, ok);
      total++; if (ic.icache_req_valid_o !== 1'b1) $display("FAIL inval_new_req: got %b want 1", ic.icache_req_valid_o); else passed++;
      grant_req(ok);
      respond(40'h5000, {32'h5003, 32'h5002, 32'h5001, 32'h5000});
      total++; if (instr !== 32'h5002) $display("FAIL inval_refetch: got %h want 00005002", instr); else passed++;
      consume();
      accept_pc(40'h6000, ok);
      grant_req(ok);
      inval = 1'b1;
      respond(40'h6000, {32'h6003, 32'h6002, 32'h6001, 32'h6000});
      inval = 1'b0;
      total++; if (instr_valid !== 1'b1 || instr !== 32'h6000)
         $display("FAIL inval_capture: got v=%b %h want v=1 00006000", instr_valid, instr); else passed++;
      consume();
      accept_pc(40'h6004, ok);
      total++; if (ic.icache_req_valid_o !== 1'b1) $display("FAIL inval_capture_cleared: got %b want 1", ic.icache_req_valid_o); else passed++;
   endtask

   task automatic test_reset_mid();
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++; if ({pc_ready, ic.icache_req_valid_o, ic.icache_req_kill_o, instr_valid} !== 4'b0000 || timeout_cnt !== 16'd0 || ic.icache_req_vpn_o !== '0)
         $display("FAIL midreset_outputs: got rdy=%b req=%b kill=%b v=%b cnt=%0d want all 0",
                  pc_ready, ic.icache_req_valid_o, ic.icache_req_kill_o, instr_valid, timeout_cnt); else passed++;
      step();
      total++; if (pc_ready !== 1'b1) $display("FAIL midreset_ready: got %b want 1", pc_ready); else passed++;
      respond(40'h6000, {4{32'h1234_5678}});
      total++; if (instr_valid !== 1'b0 || ic.icache_req_valid_o !== 1'b0)
         $display("FAIL midreset_late_resp: got v=%b req=%b want 0/0", instr_valid, ic.icache_req_valid_o); else passed++;
   endtask

   initial begin
      ic.icache_req_ready_i  = 1'b0;
      ic.icache_resp_valid_i = 1'b0;
      ic.icache_resp_data_i  = '0;
      ic.icache_resp_vaddr_i = '0;
      test_reset();
      test_miss_then_hit();
      test_stale_response();
      test_timeout();
      test_flush();
      test_backpressure_inval();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/icache_fetch_req.md
Name: icache_fetch_req

Overview:
Core-side initiator of the instruction-cache request/response interface: turns fetch PCs into ICACHE_REQ idx/vpn requests, waits for the matching ICACHE_RESP line and hands back one 32-bit instruction per accepted PC.
Sits between the fetch stage and the icache (or the hex perfect-memory model in simulation).
Keeps a one-line buffer so sequential PCs within the same 128-bit line are served without a new request.

Parameters:
ADDR_W, 40, virtual address width (addr_t)
IDX_W, 12, ICACHE_REQ_BITS_IDX width (page offset)
LINE_W, 128, icache line width (icache_line_t)
TIMEOUT_CYCLES, 64, WAIT cycles before the request is reissued

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
pc_valid_i  in  1  fetch PC valid
pc_i  in  ADDR_W  fetch PC; bits [1:0] ignored
pc_ready_o  out  1  PC accepted when pc_valid_i & pc_ready_o
flush_i  in  1  redirect: abandon current fetch
inval_i  in  1  fence.i: clear line buffer
icache_req_ready_i  in  1  icache accepts request
icache_req_valid_o  out  1  request valid
icache_req_idx_o  out  IDX_W  pc[IDX_W-1:0] with bits [3:0] zeroed
icache_req_vpn_o  out  ADDR_W-IDX_W  pc[ADDR_W-1:IDX_W]
icache_req_kill_o  out  1  one-cycle kill of outstanding request
icache_resp_valid_i  in  1  response valid
icache_resp_data_i  in  LINE_W  returned line
icache_resp_vaddr_i  in  ADDR_W  line address of response
instr_valid_o  out  1  instruction valid
instr_o  out  32  instruction word
instr_pc_o  out  ADDR_W  PC of instr_o
instr_ready_i  in  1  consumer accepts instruction
timeout_cnt_o  out  16  saturating count of reissues

Behaviour:
- Reset values: every output 0, state IDLE, line_valid 0, timeout counter 0, reissue counter 0.
- State IDLE
  - pc_ready_o = 1.
  - On acceptance, latch the PC.
  - If line_valid and latched tag pc[ADDR_W-1:4] equals buffered tag: go to HOLD (hit; instr_valid_o asserted the next cycle).
  - Otherwise go to REQ.
- State REQ
  - icache_req_valid_o = 1; idx/vpn are stable until the handshake.
  - When icache_req_ready_i = 1, go to WAIT and clear the timeout counter.
- State WAIT
  - Increment the timeout counter each cycle.
  - On icache_resp_valid_i with vaddr[ADDR_W-1:4] == latched pc[ADDR_W-1:4]: capture data and tag, set line_valid, go to HOLD.
  - Responses with a non-matching vaddr are discarded.
  - When the counter reaches TIMEOUT_CYCLES-1 with no match: pulse icache_req_kill_o, increment timeout_cnt_o (saturating at 16'hFFFF), return to REQ.
  - A match arriving in the same cycle as the timeout wins; no kill is issued.
- State HOLD
  - instr_valid_o = 1.
  - instr_o = line[pc[3:2]*32 +: 32]; word 0 is bits [31:0].
  - instr_pc_o = latched PC.
  - On instr_ready_i, go to IDLE.
  - A new PC is accepted one cycle later; there is no IDLE bypass.
- Latency
  - Buffer hit: PC accepted in cycle N, instr_valid_o in N+1.
  - Miss: req_valid_o in N+1; instr_valid_o the cycle after the matching response.
- flush_i (highest priority, any state): next state IDLE, instr_valid_o drops next cycle.
  - If in WAIT, or in REQ with ready high that cycle, also pulse icache_req_kill_o.
  - Line buffer is kept.
  - Responses arriving outside WAIT are always ignored.
- inval_i: clears line_valid next cycle.
  - If coincident with a capture in WAIT, the capture completes and HOLD delivers the instruction, but line_valid ends at 0.
- flush_i and pc_valid_i in the same IDLE cycle: the PC is not accepted (pc_ready_o is gated by ~flush_i).
- Reset mid-transaction: returns to IDLE with no kill pulse; a late response is ignored.

Decomposition:
- Shared package (drac_pkg) holds:
  - icache_line_t, icache_idx_t, icache_vpn_t, addr_t
  - fetch_state_t enum {IDLE, REQ, WAIT, HOLD}
  - ICACHE_TIMEOUT constant
- One natural sub-module, fetch_line_buffer: tag and data registers plus word-select mux, with capture and invalidate inputs.
- The FSM, timeout counter and handshake logic live in the top.

Test Plan:
- Miss, then hit in the same line:
  - Stimulus: pc 0x1000; responder returns vaddr 0x1000 with line words {0x13,0x93,0x113,0x193} 3 cycles after ready.
  - Required: instr 0x13 at pc 0x1000.
  - Then pc 0x100C: instr 0x193 one cycle after acceptance, no request issued.
- Stale response:
  - Stimulus: in WAIT for pc 0x2000, responder returns vaddr 0x3000, then vaddr 0x2000.
  - Required: first response dropped; instr from the second line only.
- Timeout:
  - Stimulus: responder silent for 64 WAIT cycles after pc 0x4000.
  - Required: kill pulse, second request with idx 0x000 and vpn 0x4, timeout_cnt_o = 1; a response then completes normally.
- Flush:
  - Stimulus: flush_i in WAIT for pc 0x5000, then the response for 0x5000 arrives while IDLE.
  - Required: kill pulse, no instr_valid_o, line buffer unchanged.
  - Required: next pc 0x5000 issues a new request.
- Backpressure and inval:
  - Stimulus: hold instr_ready_i low 5 cycles in HOLD.
  - Required: instr_o and instr_pc_o stable.
  - Stimulus: then inval_i, then the same-line pc.
  - Required: new request issued.
- Reset:
  - Stimulus: rst_i for 1 cycle while in REQ.
  - Required: all outputs 0 next cycle, pc_ready_o = 1 in the cycle after.
